// File: rtl/dma_mem_arbiter_if.sv
// rtl/dma_mem_arbiter_if.sv - requester and memory bus bundle for dma_mem_arbiter
//
// Ports carried (NREQ requesters, AW address bits):
//   req, rnw, addr, wd   per-requester request group (addr/wd packed, requester i at [i*AW +: AW] / [i*8 +: 8])
//   ack, dend, rd        per-requester grant pulse, completion pulse, shared read data
//   mem_free, mem_rd     memory side inputs: CPU leaves bus free, read data
//   mem_addr, mem_wd, mem_we, mem_oe, mem_own   memory side outputs
// Modports: slave = arbiter, master = requesters plus memory environment.
interface dma_mem_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 21
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    rnw;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*8-1:0]  wd;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    dend;
    logic [7:0]         rd;
    logic               mem_free;
    logic [AW-1:0]      mem_addr;
    logic [7:0]         mem_wd;
    logic [7:0]         mem_rd;
    logic               mem_we;
    logic               mem_oe;
    logic               mem_own;

    modport slave (
        input  req, rnw, addr, wd, mem_free, mem_rd,
        output ack, dend, rd, mem_addr, mem_wd, mem_we, mem_oe, mem_own
    );

    modport master (
        output req, rnw, addr, wd, mem_free, mem_rd,
        input  ack, dend, rd, mem_addr, mem_wd, mem_we, mem_oe, mem_own
    );
endinterface

// File: rtl/dma_mem_arbiter.sv
// rtl/dma_mem_arbiter.sv - round-robin arbiter sharing the memory bus among DMA requesters
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    dma_mem_arbiter_if.slave (requester groups, ack/dend/rd, memory bus)
// Parameters: NREQ (2..8), AW address width, MEM_LAT cycles the bus is held per access (>=1).
// Optional feature macro: DMA_ARB_PRIO0_EN - requester 0 has fixed highest priority and
//   does not move the rotation pointer; requesters 1..NREQ-1 rotate among themselves.
module dma_mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 21,
    parameter int MEM_LAT = 2
) (
    input logic            clk,
    input logic            rst_n,
    dma_mem_arbiter_if.slave bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic {IDLE, ACC} state_t;

    state_t          state;
    logic [2:0]      ptr;
    logic [2:0]      gnt_l;
    logic [CW-1:0]   cnt;
    logic            rnw_l;
    logic [NREQ-1:0] dend_r;
    logic [7:0]      rd_r;
    logic [AW-1:0]   mem_addr_r;
    logic [7:0]      mem_wd_r;
    logic            mem_we_r;
    logic            mem_oe_r;
    logic            mem_own_r;

    // Zero-padded copies so a 3-bit index is always exactly in range.
    logic [7:0]      req_x;
    logic [7:0]      rnw_x;
    logic [2:0]      idx;
    logic [2:0]      win;
    logic            win_vld;
    logic            ptr_upd;
    logic            grant;

    assign req_x = 8'(bus.req);
    assign rnw_x = 8'(bus.rnw);

    // Scan from the farthest offset down to ptr+1 so the nearest requester
    // after ptr is the last (winning) assignment.
    always_comb begin
        idx     = '0;
        win     = '0;
        win_vld = 1'b0;
        ptr_upd = 1'b1;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 3'((int'(ptr) + k) % NREQ);
            if (req_x[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
`ifdef DMA_ARB_PRIO0_EN
        if (bus.req[0]) begin
            win     = 3'd0;
            win_vld = 1'b1;
            ptr_upd = 1'b0;
        end
`endif
    end

    assign grant   = (state == IDLE) && bus.mem_free && win_vld;
    assign bus.ack = grant ? (NREQ'(1) << win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 3'(NREQ - 1);
            gnt_l      <= '0;
            cnt        <= '0;
            rnw_l      <= 1'b0;
            dend_r     <= '0;
            rd_r       <= '0;
            mem_addr_r <= '0;
            mem_wd_r   <= '0;
            mem_we_r   <= 1'b0;
            mem_oe_r   <= 1'b0;
            mem_own_r  <= 1'b0;
        end else begin
            dend_r <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        mem_addr_r <= bus.addr[win*AW +: AW];
                        mem_wd_r   <= bus.wd[win*8 +: 8];
                        rnw_l      <= rnw_x[win];
                        mem_oe_r   <= rnw_x[win];
                        mem_we_r   <= !rnw_x[win];
                        mem_own_r  <= 1'b1;
                        gnt_l      <= win;
                        if (ptr_upd) begin
                            ptr <= win;
                        end
                        cnt   <= CW'(MEM_LAT - 1);
                        state <= ACC;
                    end
                end
                ACC: begin
                    // mem_free is deliberately ignored: a started access always completes.
                    if (cnt == '0) begin
                        if (rnw_l) begin
                            rd_r <= bus.mem_rd;
                        end
                        dend_r    <= NREQ'(1) << gnt_l;
                        mem_we_r  <= 1'b0;
                        mem_oe_r  <= 1'b0;
                        mem_own_r <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dend     = dend_r;
    assign bus.rd       = rd_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_wd   = mem_wd_r;
    assign bus.mem_we   = mem_we_r;
    assign bus.mem_oe   = mem_oe_r;
    assign bus.mem_own  = mem_own_r;
endmodule
